// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with round-robin arbitration and source index.
// Define STREAM_MUX_FIXED_PRIO_EN for fixed lowest-index-wins arbitration.
module stream_mux_rr #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);

  logic [N-1:0][WIDTH-1:0] ch_data;
  logic [SEL_W-1:0]        start, gnt;
  logic                    load_en, any_vld, found;
  int                      idx;

  assign ch_data = in_data;
  assign load_en = !out_valid || out_ready;
  assign any_vld = |in_valid;

`ifdef STREAM_MUX_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [SEL_W-1:0] ptr;
  assign start = ptr;
`endif

  // First valid channel at or after start, wrapping at N-1 (not 2^SEL_W-1).
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      if (!found && in_valid[idx[SEL_W-1:0]]) begin
        gnt   = idx[SEL_W-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (!rst && load_en && any_vld) in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
`ifndef STREAM_MUX_FIXED_PRIO_EN
      ptr       <= '0;
`endif
    end else if (load_en) begin
      if (any_vld) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[gnt];
        out_sel   <= gnt;
`ifndef STREAM_MUX_FIXED_PRIO_EN
        ptr       <= (gnt == SEL_W'(N-1)) ? '0 : gnt + 1'b1;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: N=4 and N=3 instances, directed vectors.
module tb_stream_mux_rr;

`ifdef STREAM_MUX_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  v4 = '0;
  logic [31:0] d4 = '0;
  logic [3:0]  r4;
  logic        ov4;
  logic [7:0]  od4;
  logic [1:0]  os4;
  logic        ordy4 = 1'b1;
  logic [2:0]  v3 = '0;
  logic [23:0] d3 = '0;
  logic [2:0]  r3;
  logic        ov3;
  logic [7:0]  od3;
  logic [1:0]  os3;
  logic        ordy3 = 1'b1;

  exp_t q4[$];
  exp_t q3[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N(4), .WIDTH(8)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_ready(r4),
    .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(ordy4)
  );

  stream_mux_rr #(.N(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_data(d3), .in_ready(r3),
    .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(ordy3)
  );

  // Inputs change only at posedge+1, so a negedge sample sees the handshake that the next edge takes.
  always @(negedge clk) begin
    if (ov4 && ordy4) begin
      n_vec++;
      if (q4.size() == 0) begin
        n_err++;
        $display("FAIL sb4: unexpected word sel=%0d data=%h, queue empty", os4, od4);
      end else begin
        exp_t e;
        e = q4.pop_front();
        if (os4 !== e.sel || od4 !== e.data) begin
          n_err++;
          $display("FAIL sb4: got sel=%0d data=%h, expected sel=%0d data=%h", os4, od4, e.sel, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ov3 && ordy3) begin
      n_vec++;
      if (q3.size() == 0) begin
        n_err++;
        $display("FAIL sb3: unexpected word sel=%0d data=%h, queue empty", os3, od3);
      end else begin
        exp_t e;
        e = q3.pop_front();
        if (os3 !== e.sel || od3 !== e.data) begin
          n_err++;
          $display("FAIL sb3: got sel=%0d data=%h, expected sel=%0d data=%h", os3, od3, e.sel, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic void push4(input int s, input int d);
    q4.push_back('{sel: 2'(s), data: 8'(d)});
  endfunction

  function automatic void push3(input int s, input int d);
    q3.push_back('{sel: 2'(s), data: 8'(d)});
  endfunction

  initial begin
    // Reset with all channels requesting
    v4 = 4'b1111;
    d4 = {8'h13, 8'h12, 8'h11, 8'h10};
    tick(); tick();
    @(negedge clk);
    chk("rst_in_ready", int'(r4), 0);
    chk("rst_out_valid", int'(ov4), 0);
    chk("rst_out_data", int'(od4), 0);
    chk("rst_out_sel", int'(os4), 0);
    chk("rst_out_valid3", int'(ov3), 0);
    @(posedge clk); #1;

    // Round-robin sweep, one word per cycle
    rst = 1'b0;
    for (int i = 0; i < 5; i++) push4(FP ? 0 : i % 4, FP ? 8'h10 : 8'h10 + i % 4);
    repeat (5) tick();
    v4 = '0;
    tick();

    // Sparse: channel 2 alone, then channels 1 and 3 with pointer at 3
    v4 = 4'b0100;
    d4 = {8'h00, 8'hA5, 8'h00, 8'h00};
    push4(2, 8'hA5);
    tick();
    v4 = 4'b1010;
    d4 = {8'h23, 8'h00, 8'h21, 8'h00};
    push4(FP ? 1 : 3, FP ? 8'h21 : 8'h23);
    tick();
    v4 = FP ? 4'b1000 : 4'b0010;
    push4(FP ? 3 : 1, FP ? 8'h23 : 8'h21);
    tick();
    v4 = '0;
    tick();

    // Backpressure: load one word, stall, then drain and refill together
    ordy4 = 1'b0;
    v4 = 4'b1111;
    d4 = {8'h33, 8'h32, 8'h31, 8'h30};
    push4(FP ? 0 : 2, FP ? 8'h30 : 8'h32);
    tick();
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", int'(r4), 0);
      chk("stall_out_data", int'(od4), FP ? 8'h30 : 8'h32);
      chk("stall_out_sel", int'(os4), FP ? 0 : 2);
    end
    @(posedge clk); #1;
    ordy4 = 1'b1;
    #1;
    chk("release_in_ready", int'(r4), FP ? 4'b0001 : 4'b1000);
    push4(FP ? 0 : 3, FP ? 8'h30 : 8'h33);
    tick();
    v4 = '0;
    tick();

    // Reset while holding a word with the pointer at 2
    ordy4 = 1'b0;
    v4 = 4'b0010;
    d4 = {8'h43, 8'h42, 8'h41, 8'h40};
    tick();
    rst = 1'b1;
    v4 = 4'b1111;
    tick();
    @(negedge clk);
    chk("midrst_out_valid", int'(ov4), 0);
    chk("midrst_in_ready", int'(r4), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ordy4 = 1'b1;
    push4(0, 8'h40);
    push4(FP ? 0 : 1, FP ? 8'h40 : 8'h41);
    tick(); tick();
    v4 = '0;
    tick();

    // Non-power-of-two wrap with N=3
    v3 = 3'b111;
    d3 = {8'h52, 8'h51, 8'h50};
    for (int i = 0; i < 5; i++) push3(FP ? 0 : i % 3, FP ? 8'h50 : 8'h50 + i % 3);
    repeat (5) tick();
    v3 = '0;
    tick(); tick();

    chk("q4_drained", q4.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
